// File: rtl/dmem_responder_if.sv
// MEM-stage data bus between the pipeline (master) and the data memory responder (slave).
// The request fields are driven by the pipeline; the response fields and dstall are driven by the responder.
interface dmem_responder_if;
  logic        dce;
  logic [3:0]  we;
  logic [31:0] din;
  logic [31:0] daddr;
  logic [3:0]  dre;
  logic [31:0] dout;
  logic        dvalid;
  logic        dstall;
  logic        derr;

  modport master (
    output dce, we, din, daddr, dre,
    input  dout, dvalid, dstall, derr
  );

  modport slave (
    input  dce, we, din, daddr, dre,
    output dout, dvalid, dstall, derr
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-side memory responder: byte-lane RAM serviced after LATENCY wait cycles, one dvalid pulse per request.
// Optional build macro DMEM_BSWAP_EN presents a big-endian word view at the bus boundary.
module dmem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 1
) (
  input  logic             cpu_clk_50M,
  input  logic             cpu_rst,
  dmem_responder_if.slave  bus
);

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [3:0] LAT_INIT = 4'(LATENCY);
  localparam bit         HAS_WAIT = (LATENCY > 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic [31:0] bswap(input logic [31:0] w);
    bswap = {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // dre[3-k] enables byte offset k
  function automatic logic [31:0] lane_mask(input logic [31:0] w, input logic [3:0] re);
    logic [31:0] m;
    m = 32'd0;
    for (int k = 0; k < 4; k++) begin
      if (re[3-k]) begin
        m[8*k +: 8] = w[8*k +: 8];
      end else begin
        m[8*k +: 8] = 8'h00;
      end
    end
    lane_mask = m;
  endfunction

  state_t              state_r;
  state_t              state_nx_s;
  logic [3:0]          cnt_r;
  logic [3:0]          cnt_nx_s;
  logic                capture_s;
  logic                go_resp_s;

  logic [31:2]         addr_r;
  logic [3:0]          we_r;
  logic [3:0]          dre_r;
  logic [31:0]         din_r;

  logic [31:2]         req_addr_s;
  logic [3:0]          req_we_s;
  logic [3:0]          req_dre_s;
  logic [31:0]         req_din_s;

  logic [ADDR_W-1:0]   idx_s;
  logic                oor_s;
  logic                is_store_s;
  logic                wr_en_s;
  logic [3:0]          wr_lane_s;
  logic [31:0]         wr_data_s;
  logic [31:0]         rd_word_s;
  logic [31:0]         resp_data_s;

  logic [31:0]         mem [DEPTH];

  logic [31:0]         dout_r;
  logic                dvalid_r;
  logic                derr_r;

  // Request source: live bus fields in IDLE (needed when LATENCY=0), captured copy afterwards
  always_comb begin
    if (state_r == IDLE) begin
      req_addr_s = bus.daddr[31:2];
      req_we_s   = bus.we;
      req_dre_s  = bus.dre;
      req_din_s  = bus.din;
    end else begin
      req_addr_s = addr_r;
      req_we_s   = we_r;
      req_dre_s  = dre_r;
      req_din_s  = din_r;
    end
  end

  // Next-state, wait counter and response-strobe logic
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    capture_s  = 1'b0;
    go_resp_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.dce) begin
          capture_s = 1'b1;
          cnt_nx_s  = LAT_INIT;
          if (HAS_WAIT) begin
            state_nx_s = WAIT;
          end else begin
            state_nx_s = RESP;
            go_resp_s  = 1'b1;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      WAIT: begin
        cnt_nx_s = cnt_r - 4'd1;
        if (cnt_r <= 4'd1) begin
          state_nx_s = RESP;
          go_resp_s  = 1'b1;
        end else begin
          state_nx_s = WAIT;
        end
      end
      RESP: begin
        state_nx_s = IDLE;
      end
      default: begin
        state_nx_s = IDLE;
        cnt_nx_s   = 4'd0;
      end
    endcase
  end

  // Address decode, lane mapping and read-data shaping for the response edge
  always_comb begin
    idx_s      = req_addr_s[ADDR_W+1:2];
    oor_s      = ((req_addr_s >> ADDR_W) != 30'd0);
    is_store_s = (req_we_s != 4'd0);
`ifdef DMEM_BSWAP_EN
    wr_data_s  = bswap(req_din_s);
    wr_lane_s  = {req_we_s[0], req_we_s[1], req_we_s[2], req_we_s[3]};
    rd_word_s  = bswap(mem[idx_s]);
`else
    wr_data_s  = req_din_s;
    wr_lane_s  = req_we_s;
    rd_word_s  = mem[idx_s];
`endif
    wr_en_s    = go_resp_s && is_store_s && !oor_s;
    if (is_store_s || oor_s) begin
      resp_data_s = 32'd0;
    end else begin
      resp_data_s = lane_mask(rd_word_s, req_dre_s);
    end
  end

  // Control state, captured request and registered response outputs
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      state_r  <= IDLE;
      cnt_r    <= 4'd0;
      addr_r   <= 30'd0;
      we_r     <= 4'd0;
      dre_r    <= 4'd0;
      din_r    <= 32'd0;
      dout_r   <= 32'd0;
      dvalid_r <= 1'b0;
      derr_r   <= 1'b0;
    end else begin
      state_r  <= state_nx_s;
      cnt_r    <= cnt_nx_s;
      if (capture_s) begin
        addr_r <= bus.daddr[31:2];
        we_r   <= bus.we;
        dre_r  <= bus.dre;
        din_r  <= bus.din;
      end
      dvalid_r <= go_resp_s;
      derr_r   <= go_resp_s && oor_s;
      if (go_resp_s) begin
        dout_r <= resp_data_s;
      end
    end
  end

  // Byte-lane RAM; not cleared by reset, and a store whose commit edge coincides with reset is dropped
  always_ff @(posedge cpu_clk_50M) begin
    if (!cpu_rst && wr_en_s) begin
      for (int k = 0; k < 4; k++) begin
        if (wr_lane_s[k]) begin
          mem[idx_s][8*k +: 8] <= wr_data_s[8*k +: 8];
        end
      end
    end
  end

  assign bus.dout   = dout_r;
  assign bus.dvalid = dvalid_r;
  assign bus.derr   = derr_r;
  assign bus.dstall = ((state_r == IDLE) && bus.dce) || (state_r == WAIT);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances at LATENCY 0, 1 and 4 sharing clock and reset.
module tb_dmem_responder;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  dmem_responder_if b0 ();
  dmem_responder_if b1 ();
  dmem_responder_if b2 ();

  dmem_responder #(.ADDR_W(10), .LATENCY(0)) u0 (.cpu_clk_50M(clk), .cpu_rst(rst), .bus(b0));
  dmem_responder #(.ADDR_W(10), .LATENCY(1)) u1 (.cpu_clk_50M(clk), .cpu_rst(rst), .bus(b1));
  dmem_responder #(.ADDR_W(10), .LATENCY(4)) u2 (.cpu_clk_50M(clk), .cpu_rst(rst), .bus(b2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input int u, input logic c, input logic [3:0] w, input logic [31:0] d,
                       input logic [31:0] a, input logic [3:0] r);
    case (u)
      0: begin b0.dce = c; b0.we = w; b0.din = d; b0.daddr = a; b0.dre = r; end
      1: begin b1.dce = c; b1.we = w; b1.din = d; b1.daddr = a; b1.dre = r; end
      default: begin b2.dce = c; b2.we = w; b2.din = d; b2.daddr = a; b2.dre = r; end
    endcase
  endtask

  // {dstall, dvalid, derr, dout}
  function automatic logic [34:0] obs(input int u);
    case (u)
      0: obs = {b0.dstall, b0.dvalid, b0.derr, b0.dout};
      1: obs = {b1.dstall, b1.dvalid, b1.derr, b1.dout};
      default: obs = {b2.dstall, b2.dvalid, b2.derr, b2.dout};
    endcase
  endfunction

  // Issue one request at the current point (just after a falling edge) and record what happens.
  // lat: cycles from request to dvalid (-1 on timeout); stalls: dstall cycles (+100 if stalled in RESP);
  // after: outputs in the cycle following the response.
  task automatic run_txn(input int u, input logic [3:0] w, input logic [31:0] d, input logic [31:0] a,
                         input logic [3:0] r, output int lat, output int stalls, output logic [31:0] rd,
                         output logic er, output logic [34:0] after);
    logic [34:0] o;
    int c;
    bit done;
    drive(u, 1'b1, w, d, a, r);
    #1;
    o = obs(u);
    stalls = o[34] ? 1 : 0;
    lat = -1; rd = 32'd0; er = 1'b0; c = 0; done = 1'b0;
    while (!done && c < 40) begin
      @(negedge clk); #1;
      c++;
      o = obs(u);
      if (o[33]) begin
        lat = c; rd = o[31:0]; er = o[32]; done = 1'b1;
        if (o[34]) stalls += 100;
      end else if (o[34]) begin
        stalls++;
      end
    end
    drive(u, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0);
    @(negedge clk); #1;
    after = obs(u);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(0, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0);
    drive(1, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0);
    drive(2, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    for (int u = 0; u < 3; u++) begin
      total++;
      if (obs(u) !== 35'd0) begin bad++; $display("FAIL reset_outputs u%0d got=%h exp=%h", u, obs(u), 35'd0); end
    end
  endtask

  task automatic test_sw_lw;
    int lat, st; logic [31:0] rd; logic er; logic [34:0] af;
    run_txn(1, 4'b1111, 32'hA1B2C3D4, 32'h00000010, 4'b0000, lat, st, rd, er, af);
    total++; if (lat !== 2) begin bad++; $display("FAIL sw_latency got=%0d exp=2", lat); end
    total++; if (st !== 2) begin bad++; $display("FAIL sw_stall_cycles got=%0d exp=2", st); end
    total++; if ({er, rd} !== {1'b0, 32'd0}) begin bad++; $display("FAIL sw_resp got=%h exp=%h", {er, rd}, 33'd0); end
    run_txn(1, 4'b0000, 32'd0, 32'h00000010, 4'b1111, lat, st, rd, er, af);
    total++; if (lat !== 2) begin bad++; $display("FAIL lw_latency got=%0d exp=2", lat); end
    total++; if (st !== 2) begin bad++; $display("FAIL lw_stall_cycles got=%0d exp=2", st); end
    total++; if ({er, rd} !== {1'b0, 32'hA1B2C3D4}) begin bad++; $display("FAIL lw_data got=%h exp=%h", {er, rd}, {1'b0, 32'hA1B2C3D4}); end
    total++; if (af !== {3'b000, 32'hA1B2C3D4}) begin bad++; $display("FAIL lw_hold got=%h exp=%h", af, {3'b000, 32'hA1B2C3D4}); end
  endtask

  task automatic test_sb;
    int lat, st; logic [31:0] rd; logic er; logic [34:0] af;
    run_txn(1, 4'b0100, 32'h5A5A5A5A, 32'h00000010, 4'b0000, lat, st, rd, er, af);
    total++; if (af !== 35'd0) begin bad++; $display("FAIL sb_after got=%h exp=%h", af, 35'd0); end
    run_txn(1, 4'b0000, 32'd0, 32'h00000010, 4'b1111, lat, st, rd, er, af);
    total++; if (rd !== 32'hA15AC3D4) begin bad++; $display("FAIL sb_readback got=%h exp=%h", rd, 32'hA15AC3D4); end
  endtask

  task automatic test_masking;
    int lat, st; logic [31:0] rd; logic er; logic [34:0] af;
    run_txn(1, 4'b0000, 32'd0, 32'h00000012, 4'b0011, lat, st, rd, er, af);
    total++; if (rd !== 32'hA15A0000) begin bad++; $display("FAIL lh_mask got=%h exp=%h", rd, 32'hA15A0000); end
    run_txn(1, 4'b0000, 32'd0, 32'h00000010, 4'b1000, lat, st, rd, er, af);
    total++; if (rd !== 32'h000000D4) begin bad++; $display("FAIL lb_mask got=%h exp=%h", rd, 32'h000000D4); end
  endtask

  task automatic test_malformed;
    int lat, st; logic [31:0] rd; logic er; logic [34:0] af;
    run_txn(1, 4'b0011, 32'h0000BEEF, 32'h00000010, 4'b1111, lat, st, rd, er, af);
    total++; if ({er, rd} !== 33'd0) begin bad++; $display("FAIL malformed_resp got=%h exp=%h", {er, rd}, 33'd0); end
    run_txn(1, 4'b0000, 32'd0, 32'h00000010, 4'b1111, lat, st, rd, er, af);
    total++; if (rd !== 32'hA15ABEEF) begin bad++; $display("FAIL malformed_readback got=%h exp=%h", rd, 32'hA15ABEEF); end
  endtask

  task automatic test_out_of_range;
    int lat, st; logic [31:0] rd; logic er; logic [34:0] af;
    run_txn(1, 4'b1111, 32'h11223344, 32'h00000000, 4'b0000, lat, st, rd, er, af);
    run_txn(1, 4'b1111, 32'hFFFFFFFF, 32'h00001000, 4'b0000, lat, st, rd, er, af);
    total++; if (lat !== 2) begin bad++; $display("FAIL oor_sw_latency got=%0d exp=2", lat); end
    total++; if ({er, rd} !== {1'b1, 32'd0}) begin bad++; $display("FAIL oor_sw_derr got=%h exp=%h", {er, rd}, {1'b1, 32'd0}); end
    total++; if (af !== 35'd0) begin bad++; $display("FAIL oor_derr_clear got=%h exp=%h", af, 35'd0); end
    run_txn(1, 4'b0000, 32'd0, 32'h00000000, 4'b1111, lat, st, rd, er, af);
    total++; if ({er, rd} !== {1'b0, 32'h11223344}) begin bad++; $display("FAIL oor_ram_intact got=%h exp=%h", {er, rd}, {1'b0, 32'h11223344}); end
    run_txn(1, 4'b0000, 32'd0, 32'h00001000, 4'b1111, lat, st, rd, er, af);
    total++; if ({er, rd} !== {1'b1, 32'd0}) begin bad++; $display("FAIL oor_lw got=%h exp=%h", {er, rd}, {1'b1, 32'd0}); end
  endtask

  task automatic test_back_to_back_lat0;
    int lat, st; logic [31:0] rd; logic er; logic [34:0] af;
    run_txn(0, 4'b1111, 32'h01020304, 32'h00000020, 4'b0000, lat, st, rd, er, af);
    total++; if (lat !== 1) begin bad++; $display("FAIL lat0_latency got=%0d exp=1", lat); end
    total++; if (st !== 1) begin bad++; $display("FAIL lat0_stall_cycles got=%0d exp=1", st); end
    total++; if (af !== 35'd0) begin bad++; $display("FAIL lat0_idle_after got=%h exp=%h", af, 35'd0); end
    run_txn(0, 4'b0000, 32'd0, 32'h00000020, 4'b1111, lat, st, rd, er, af);
    total++; if (st !== 1) begin bad++; $display("FAIL lat0_b2b_stall got=%0d exp=1", st); end
    total++; if ({lat, rd} !== {32'd1, 32'h01020304}) begin bad++; $display("FAIL lat0_b2b_load lat=%0d got=%h exp=%h", lat, rd, 32'h01020304); end
  endtask

  task automatic test_reset_in_wait;
    int lat, st, pulses; logic [31:0] rd; logic er; logic [34:0] af;
    run_txn(2, 4'b1111, 32'hCAFEF00D, 32'h00000040, 4'b0000, lat, st, rd, er, af);
    total++; if ({lat, st} !== {32'd5, 32'd5}) begin bad++; $display("FAIL lat4_timing got lat=%0d stalls=%0d exp 5 5", lat, st); end
    pulses = 0;
    drive(2, 1'b1, 4'b1111, 32'hDEADBEEF, 32'h00000040, 4'b0000);
    @(negedge clk); #1;
    if (obs(2) & 35'h2_0000_0000) pulses++;
    drive(2, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0);
    @(negedge clk); #1;
    if (obs(2) & 35'h2_0000_0000) pulses++;
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    total++; if (obs(2) !== 35'd0) begin bad++; $display("FAIL rst_wait_outputs got=%h exp=%h", obs(2), 35'd0); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      if (obs(2) & 35'h2_0000_0000) pulses++;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL rst_wait_no_dvalid got=%0d exp=0", pulses); end
    run_txn(2, 4'b0000, 32'd0, 32'h00000040, 4'b1111, lat, st, rd, er, af);
    total++; if ({lat, rd} !== {32'd5, 32'hCAFEF00D}) begin bad++; $display("FAIL rst_wait_old_data lat=%0d got=%h exp=%h", lat, rd, 32'hCAFEF00D); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    @(negedge clk); #1;
    test_sw_lw();
    test_sb();
    test_masking();
    test_malformed();
    test_out_of_range();
    test_back_to_back_lat0();
    test_reset_in_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-side memory responder at the far end of the MEM-stage data bus.
- Consumes the MEM stage's request signals: dce, we, din, daddr, dre.
- Services each request from an internal byte-lane RAM after a programmable wait.
- Holds the pipeline with dstall while busy, then returns read data with a one-cycle dvalid pulse.

Parameters:
- ADDR_W, 10, word-address width. RAM depth is 2^ADDR_W words (default 4 KB).
- LATENCY, 1, wait cycles inserted between request acceptance and response. Legal range 0..15.

Ports:
- cpu_clk_50M  input  1  system clock; all state updates on the rising edge.
- cpu_rst  input  1  reset, synchronous, active-high.
- dce  input  1  request valid; one request per assertion while in IDLE.
- we  input  4  store byte enables; we[k] writes byte offset k, i.e. bits [8k+7:8k]; all-zero means load.
- din  input  32  store data, already lane-replicated by the MEM stage.
- daddr  input  32  physical byte address; bits [1:0] are ignored for RAM indexing.
- dre  input  4  load byte enables; dre[3-k] enables byte offset k.
- dout  output  32  load data, valid only while dvalid=1.
- dvalid  output  1  one-cycle response pulse (issued for loads and stores).
- dstall  output  1  pipeline hold request.
- derr  output  1  out-of-range flag, qualified by dvalid.

Behaviour:
- Reset (cpu_rst=1 at an edge):
  - State goes to IDLE; dout=0, dvalid=0, derr=0, wait counter=0.
  - RAM contents are not cleared.
  - An in-flight store that has not yet committed is dropped.
- States: IDLE, WAIT, RESP.
- IDLE:
  - When dce=1, capture daddr, we, din, dre and load cnt=LATENCY.
  - Next state is WAIT if LATENCY>0, otherwise RESP.
  - When dce=0, remain in IDLE.
- WAIT:
  - cnt decrements each cycle.
  - When cnt==1, the next state is RESP.
- Entering RESP (the edge leaving WAIT, or leaving IDLE when LATENCY=0):
  - Store (captured we!=0): the RAM word at daddr[ADDR_W+1:2] is written on the lanes with we[k]=1. Other lanes are unchanged.
  - Load: dout is registered with the RAM word, and lanes whose dre bit is 0 are forced to 0.
  - A store forces dout=0.
- RESP:
  - dvalid=1 for exactly one cycle.
  - Next state is IDLE unconditionally.
  - dce is ignored in RESP, because it still carries the request that was just serviced.
- dstall is combinational: dstall = (IDLE & dce) | WAIT. It is 0 in RESP and in IDLE without a request.
- Latency: request seen in IDLE at cycle T gives dvalid at cycle T+LATENCY+1.
- Throughput: one request per LATENCY+2 cycles.
- Out of range (any of daddr[31:ADDR_W+2] nonzero):
  - The store is suppressed and a load returns dout=0.
  - derr=1 together with dvalid.
  - The cycle timing is unchanged.
- Malformed enables (we!=0 and dre!=0 together): treated as a store; dre is ignored.
- dout holds its value after RESP until the next response or reset.
- dvalid and derr are 0 outside RESP.
- Reset asserted in WAIT or RESP returns to IDLE at that edge with no dvalid pulse.

Optional Feature:
- Macro: DMEM_BSWAP_EN.
- When defined:
  - Byte order is reversed at the bus boundary: din is swapped {[7:0],[15:8],[23:16],[31:24]} before the RAM write.
  - we lane k maps to RAM lane 3-k.
  - The RAM word is swapped the same way before dre masking.
  - Result: a big-endian word view.
- When undefined: no swap, lanes as described in Ports.
- Timing and all other behaviour are identical in both builds.

Test Plan:
- SW, then LW, with LATENCY=1:
  - Stimulus: dce=1, we=4'b1111, daddr=0x00000010, din=0xA1B2C3D4. Then dce=1, dre=4'b1111, daddr=0x00000010.
  - Required: each request gets dstall for 2 cycles and dvalid at T+2; the load returns dout=0xA1B2C3D4 with derr=0.
- SB, then full LW:
  - Stimulus: SB with we=4'b0100, din=0x5A5A5A5A to 0x10 (holding 0xA1B2C3D4), then LW.
  - Required: dout=0xA15AC3D4.
- LH masking:
  - Stimulus: dre=4'b0011 at 0x12, word = 0xA15AC3D4.
  - Required: dout=0xA15A0000.
- LATENCY=0:
  - Stimulus: dce held high for one request.
  - Required: dstall=1 for 1 cycle, dvalid at T+1, state back in IDLE at T+2.
- Out of range with ADDR_W=10:
  - Stimulus: SW to 0x00001000 with din=0xFFFFFFFF, then LW from 0x00000000 (holding 0x11223344).
  - Required: the store gives derr=1 with dvalid; the load returns 0x11223344 (RAM unchanged).
- Reset mid-WAIT with LATENCY=4:
  - Stimulus: assert cpu_rst 2 cycles after a store is accepted.
  - Required: no dvalid, dstall=0 in the cycle after reset, and a subsequent load of that word shows the old contents.
